// File: rtl/otter_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the arbiter and the
// register-file write port.
interface otter_wb_arbiter_if;
  // Handshake: a transfer completes in a cycle where valid && ready are both
  // high. A requester holds valid, addr and data stable until it sees ready.
  // Ready may be high while valid is low and carries no meaning then.
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        init_done;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, w_en, w_addr, w_data, init_done
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, w_en, w_addr, w_data, init_done
  );
endinterface

// File: rtl/otter_wb_arbiter.sv
// OTTER register-file write-port controller: zero-sweeps x1..x31 after reset,
// then arbitrates A (fixed priority) against B (with a starvation guard).
module otter_wb_arbiter #(
  parameter int unsigned MAX_WAIT   = 3,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  otter_wb_arbiter_if.slave        bus,
  output logic                     dbg_state,
  output logic [3:0]               dbg_wait_cnt
);
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam state_e     RESET_STATE = INIT_CLEAR ? ST_INIT : ST_ARB;

  state_e      state_q, state_d;
  logic [4:0]  init_cnt_q, init_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        w_en_q, w_en_d;
  logic [4:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;

  logic starve;
  logic a_ready_c, b_ready_c;
  logic a_acc, b_acc;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    w_en_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    starve     = 1'b0;
    a_ready_c  = 1'b0;
    b_ready_c  = 1'b0;
    a_acc      = 1'b0;
    b_acc      = 1'b0;

    case (state_q)
      ST_INIT: begin
        w_en_d     = 1'b1;
        w_addr_d   = init_cnt_q;
        w_data_d   = '0;
        init_cnt_d = init_cnt_q + 5'd1;
        wait_cnt_d = '0;
        if (init_cnt_q == 5'd31) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        // A owns the port unless B has already waited MAX_WAIT cycles.
        starve    = bus.b_valid && (wait_cnt_q == MAX_WAIT_C);
        a_ready_c = !starve;
        b_ready_c = !bus.a_valid || starve;
        a_acc     = bus.a_valid && a_ready_c;
        b_acc     = bus.b_valid && b_ready_c && !a_acc;

        if (a_acc) begin
          w_en_d   = (bus.a_addr != 5'd0);
          w_addr_d = bus.a_addr;
          w_data_d = bus.a_data;
        end else if (b_acc) begin
          w_en_d   = (bus.b_addr != 5'd0);
          w_addr_d = bus.b_addr;
          w_data_d = bus.b_data;
        end

        if (bus.b_valid && !b_ready_c) begin
          if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= 5'd1;
      wait_cnt_q <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
    end
  end

  // Readies and init_done are forced low while rst is held, before any edge.
  assign bus.a_ready   = a_ready_c && !rst;
  assign bus.b_ready   = b_ready_c && !rst;
  assign bus.init_done = (state_q == ST_ARB) && !rst;
  assign bus.w_en      = w_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;

  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;
endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Bench for otter_wb_arbiter: directed scenarios plus random traffic checked
// against a cycle-level priority model and an expected-write queue.
module tb_otter_wb_arbiter;
  localparam int MAX_WAIT  = 3;
  localparam int SWEEP_LEN = 31;

  logic       clk;
  logic       rst;
  logic       dbg_state, dbg0_state;
  logic [3:0] dbg_wait, dbg0_wait;

  otter_wb_arbiter_if bif ();
  otter_wb_arbiter_if bif0 ();

  otter_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .INIT_CLEAR(1'b1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bif),
    .dbg_state    (dbg_state),
    .dbg_wait_cnt (dbg_wait)
  );

  otter_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .INIT_CLEAR(1'b0)) u_ic0 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bif0),
    .dbg_state    (dbg0_state),
    .dbg_wait_cnt (dbg0_wait)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [36:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int b_stall  = 0;
  bit last_ga  = 1'b0;
  bit last_gb  = 1'b0;
  logic obs_a_ready, obs_b_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_a_ready", 64'(bif.a_ready), 64'(0));
      check("rst_b_ready", 64'(bif.b_ready), 64'(0));
      check("rst_init_done", 64'(bif.init_done), 64'(0));
      check("rst_ic0_init_done", 64'(bif0.init_done), 64'(0));
      @(posedge clk);
      #1;
      check("rst_w_en", 64'(bif.w_en), 64'(0));
      check("rst_ic0_w_en", 64'(bif0.w_en), 64'(0));
    end
    rst = 1'b0;
    cyc = 0;
    b_stall = 0;
    last_ga = 1'b0;
    last_gb = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: predict grants from the priority rules, check readies,
  // then check the registered write port after the edge.
  task automatic tick();
    bit arb, starve, ga, gb;
    logic [36:0] e;
    @(negedge clk);
    arb    = (cyc >= SWEEP_LEN);
    starve = arb && bif.b_valid && (b_stall >= MAX_WAIT);
    ga     = arb && !starve && bif.a_valid;
    gb     = arb && bif.b_valid && !ga;
    obs_a_ready = bif.a_ready;
    obs_b_ready = bif.b_ready;
    check("a_ready", 64'(bif.a_ready), 64'(arb && !starve));
    check("b_ready", 64'(bif.b_ready), 64'(arb && !(bif.a_valid && !starve)));
    check("init_done", 64'(bif.init_done), 64'(arb));
    check("wait_cnt", 64'(dbg_wait), 64'(b_stall));
    check("ic0_init_done", 64'(bif0.init_done), 64'(1));
    check("ic0_a_ready", 64'(bif0.a_ready), 64'(1));
    check("ic0_b_ready", 64'(bif0.b_ready), 64'(0));

    if (!arb)
      exp_q.push_back({5'(cyc + 1), 32'h0});
    else if (ga && bif.a_addr != 5'd0)
      exp_q.push_back({bif.a_addr, bif.a_data});
    else if (gb && bif.b_addr != 5'd0)
      exp_q.push_back({bif.b_addr, bif.b_data});

    if (!arb || gb || !bif.b_valid) b_stall = 0;
    else b_stall++;
    last_ga = ga;
    last_gb = gb;

    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("w_en", 64'(bif.w_en), 64'(1));
      check("w_addr", 64'(bif.w_addr), 64'(e[36:32]));
      check("w_data", 64'(bif.w_data), 64'(e[31:0]));
    end else begin
      check("w_en_idle", 64'(bif.w_en), 64'(0));
    end
    check("ic0_w_en", 64'(bif0.w_en), 64'(1));
    check("ic0_w_addr", 64'(bif0.w_addr), 64'(3));
    check("ic0_w_data", 64'(bif0.w_data), 64'(32'h77));
  endtask

  // driver: new request only once the previous one was taken
  task automatic drive_random();
    if (!bif.a_valid || last_ga) begin
      bif.a_valid = ($urandom_range(0, 99) < 60);
      bif.a_addr  = 5'($urandom_range(0, 31));
      bif.a_data  = $urandom();
    end
    if (!bif.b_valid || last_gb) begin
      bif.b_valid = ($urandom_range(0, 99) < 50);
      bif.b_addr  = 5'($urandom_range(0, 31));
      bif.b_data  = $urandom();
    end
  endtask

  initial begin
    int waited;
    logic [31:0] a_vals [3];
    a_vals[0] = 32'h11;
    a_vals[1] = 32'h22;
    a_vals[2] = 32'h33;

    bif0.a_valid = 1'b1; bif0.a_addr = 5'd3; bif0.a_data = 32'h77;
    bif0.b_valid = 1'b0; bif0.b_addr = 5'd0; bif0.b_data = 32'h0;
    bif.a_valid = 1'b1; bif.a_addr = 5'd12; bif.a_data = $urandom();
    bif.b_valid = 1'b1; bif.b_addr = 5'd13; bif.b_data = $urandom();
    rst = 1'b1;

    // reset sweep with both requesters pending
    do_reset(3);
    repeat (SWEEP_LEN) tick();
    tick();
    check("sweep_first_grant_a", 64'(last_ga), 64'(1));
    bif.a_valid = 1'b0;
    tick();
    check("sweep_then_b", 64'(last_gb), 64'(1));
    bif.b_valid = 1'b0;

    // A-only stream
    for (int i = 0; i < 3; i++) begin
      bif.a_valid = 1'b1;
      bif.a_addr  = 5'(5 + i);
      bif.a_data  = a_vals[i];
      tick();
      check("a_stream_ready", 64'(obs_a_ready), 64'(1));
    end
    bif.a_valid = 1'b0;
    tick();

    // x0 write: accepted, no register-file write
    bif.a_valid = 1'b1; bif.a_addr = 5'd0; bif.a_data = 32'hFFFF_FFFF;
    tick();
    check("x0_accept", 64'(last_ga), 64'(1));
    bif.a_valid = 1'b0;
    tick();

    // starvation guard
    bif.a_valid = 1'b1; bif.a_addr = 5'd1; bif.a_data = $urandom();
    bif.b_valid = 1'b1; bif.b_addr = 5'd9; bif.b_data = 32'hDEAD_BEEF;
    waited = 0;
    for (int i = 0; i < 8 && !last_gb; i++) begin
      tick();
      if (!last_gb) waited++;
      if (last_ga) begin
        bif.a_addr = 5'($urandom_range(1, 31));
        bif.a_data = $urandom();
      end
    end
    check("starve_wait", 64'(waited), 64'(MAX_WAIT));
    check("starve_b_ready", 64'(obs_b_ready), 64'(1));
    check("starve_a_blocked", 64'(obs_a_ready), 64'(0));
    bif.b_valid = 1'b0;
    tick();
    check("a_resume", 64'(last_ga), 64'(1));
    bif.a_valid = 1'b0;
    tick();

    // B alone
    bif.b_valid = 1'b1; bif.b_addr = 5'd31; bif.b_data = 32'h5A5A_5A5A;
    tick();
    check("b_alone_ready", 64'(obs_b_ready), 64'(1));
    check("b_alone_wait", 64'(dbg_wait), 64'(0));
    bif.b_valid = 1'b0;
    tick();

    // random traffic
    repeat (400) begin
      drive_random();
      tick();
    end

    // reset mid-sweep, then full sweep restart
    do_reset(2);
    repeat (10) begin
      drive_random();
      tick();
    end
    do_reset(2);
    repeat (SWEEP_LEN + 20) begin
      drive_random();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/otter_wb_arbiter.md
# otter_wb_arbiter

Write-port controller for the OTTER register file. It clears registers x1..x31 to zero after reset, then shares the single register-file write port between two writeback requesters. Requester A is the pipeline writeback stage. Requester B is the multi-cycle unit, such as the divider or the load return path. The block sits directly in front of the register file's w_en/w_addr/w_data inputs and uses fixed priority for A with a starvation guard for B.

## Interface
- MAX_WAIT, default 3: cycles B may be stalled by A before B is force-granted; range 1..15.
- INIT_CLEAR, default 1: when 1, perform the zero-sweep after reset; when 0, enter arbitration immediately.
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  A has a write pending.
- a_ready  output  1  A write accepted this cycle when a_valid=1.
- a_addr  input  5  A destination register.
- a_data  input  32  A write data.
- b_valid  input  1  B has a write pending.
- b_ready  output  1  B write accepted this cycle when b_valid=1.
- b_addr  input  5  B destination register.
- b_data  input  32  B write data.
- w_en  output  1  register-file write enable, registered.
- w_addr  output  5  register-file write address, registered.
- w_data  output  32  register-file write data, registered.
- init_done  output  1  high once arbitration is active.

## Operation
- States:
  - INIT: clear sweep.
  - ARB: normal operation.
- Reset behaviour:
  - rst=1 loads state=INIT if INIT_CLEAR=1, else ARB.
  - rst=1 also sets init_cnt=1 and wait_cnt=0.
  - All outputs are 0 during reset, including combinational a_ready and b_ready.
- INIT state:
  - Each cycle registers w_en=1, w_addr=init_cnt, w_data=0, then init_cnt increments.
  - The transition to ARB occurs on the edge that registers w_addr=31.
  - a_ready=b_ready=0 and init_done=0 throughout INIT.
- ARB state, combinational grant:
  - starve = b_valid && (wait_cnt == MAX_WAIT).
  - a_ready = !starve.
  - b_ready = !a_valid || starve.
- ARB state, registered write:
  - An accepted transfer (valid && ready) registers w_en=1 and the matching addr/data on the next edge.
  - Only one transfer is accepted per cycle.
  - With no accept, the next edge registers w_en=0, with w_addr and w_data held.
  - Writes to addr 0 are accepted (ready asserted, handshake completes) but register w_en=0.
- wait_cnt, 4 bits:
  - Increments when b_valid && !b_ready, saturating at MAX_WAIT.
  - Clears on B accept or when b_valid=0.
- Same-address conflict: if A and B target the same register in consecutive accepts, the register file receives the writes in accept order and the last write wins. No merging or reordering.
- init_done = (state == ARB).
- Reset mid-sweep: the sweep restarts from x1 after rst deasserts.
- Reset mid-operation: a registered pending write is dropped (w_en=0).

## Timing
- Cycle 0 is the first cycle with rst=0.
- With INIT_CLEAR=1:
  - Cycles 1..31: w_en=1 with w_addr=1..31 respectively, w_data=0.
  - Cycle 31 onward: state=ARB and init_done=1; ready signals are valid in cycle 31.
- With INIT_CLEAR=0: init_done=1 and the ready signals are live from cycle 0.
- Write latency:
  - An accept in cycle N drives w_en in cycle N+1.
  - The register file commits at the end of N+1.
  - The value is readable in cycle N+2.
- Throughput: one write per cycle, sustained.
- Requesters must hold valid, addr and data stable until ready.
- Worst-case B stall: MAX_WAIT cycles with A continuously valid, then B is granted on cycle MAX_WAIT+1 of waiting.
- When B is starve-granted, A stalls exactly one cycle.

## Test plan
- Reset sweep:
  - Stimulus: INIT_CLEAR=1, release rst, hold a_valid=b_valid=1.
  - Required: w_en=1 with w_addr 1..31 and w_data=0 in cycles 1..31; no ready asserted before cycle 31; init_done rises in cycle 31.
- A-only stream:
  - Stimulus: a_valid=1 with addr 5,6,7 and data 0x11,0x22,0x33 in cycles N..N+2.
  - Required: w_* shows those values in cycles N+1..N+3; a_ready=1 throughout.
- Starvation guard:
  - Stimulus: MAX_WAIT=3, a_valid and b_valid held high from cycle N, b_addr=9, b_data=0xDEADBEEF.
  - Required: b_ready=0 in N..N+2 and b_ready=1 with a_ready=0 in N+3; w_addr=9, w_data=0xDEADBEEF in N+4; A resumes in N+4.
- x0 drop:
  - Stimulus: a_addr=0, a_data=0xFFFFFFFF, a_valid=1.
  - Required: a_ready=1, w_en=0 the next cycle.
- Reset mid-sweep:
  - Stimulus: assert rst at sweep cycle 10, release.
  - Required: w_en=0 during reset; the sweep restarts at w_addr=1; init_done=0 until 31 cycles later.
- B alone:
  - Stimulus: a_valid=0, b_valid=1, b_addr=31, b_data=0x5A5A5A5A.
  - Required: b_ready=1 immediately, write in the next cycle, wait_cnt stays 0.
